// File: rtl/row_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : row_scan_driver
// Brief    : Double-buffered frame store that collects image rows and scans
//            the completed frame row by row onto an LED dot-matrix driver.
// Revision : 1.0 - initial release
// ============================================================================
module row_scan_driver #(
    parameter int WIDTH = 80,
    parameter int ROWS  = 41,
    parameter int HOLD  = 1000,
    parameter int SEL_W = 6
) (
    input  logic             cnt,
    input  logic             rst,
    input  logic [WIDTH-1:0] row_in,
    input  logic             row_valid,
    input  logic             frame_start,
    output logic             row_ready,
    output logic [WIDTH-1:0] col_out,
    output logic [SEL_W-1:0] row_sel,
    output logic             row_en,
    output logic             frame_swap
);

    localparam int                HOLD_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [SEL_W-1:0]  C_LAST_ROW  = SEL_W'(ROWS - 1);
    localparam logic [HOLD_W-1:0] C_LAST_HOLD = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Two frame banks; r_frontSel names the bank being displayed.
    logic [WIDTH-1:0]  r_mem [2][ROWS];

    logic [SEL_W-1:0]  r_wrIdx;
    logic              r_backFull;
    logic              r_frontValid;
    logic              r_frontSel;
    state_t            r_state;
    logic [SEL_W-1:0]  r_row;
    logic [HOLD_W-1:0] r_holdCnt;

    logic              w_accept;
    logic [SEL_W-1:0]  w_wrAddr;
    state_t            w_stateNext;
    logic [SEL_W-1:0]  w_rowNext;
    logic [HOLD_W-1:0] w_holdNext;
    logic              w_swap;
    logic              w_frontNext;
    logic              w_showNext;

    assign row_ready = !r_backFull;
    assign row_sel   = r_row;
    assign w_accept  = row_valid && !r_backFull;
    // A frame_start row always lands at index 0, discarding any partial frame.
    assign w_wrAddr  = frame_start ? '0 : r_wrIdx;

    always_ff @(posedge cnt) begin
        if (w_accept) begin
            r_mem[~r_frontSel][w_wrAddr] <= row_in;
        end
    end

    always_ff @(posedge cnt) begin
        if (rst) begin
            r_wrIdx    <= '0;
            r_backFull <= 1'b0;
        end else if (w_accept) begin
            if (w_wrAddr == C_LAST_ROW) begin
                r_wrIdx    <= '0;
                r_backFull <= 1'b1;
            end else begin
                r_wrIdx <= w_wrAddr + 1'b1;
            end
        end else if (w_swap) begin
            r_backFull <= 1'b0;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_rowNext   = r_row;
        w_holdNext  = r_holdCnt;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_backFull) begin
                    w_swap      = 1'b1;
                    w_stateNext = ST_SHOW;
                    w_rowNext   = '0;
                    w_holdNext  = '0;
                end
            end
            ST_SHOW: begin
                if (r_holdCnt == C_LAST_HOLD) begin
                    w_stateNext = ST_BLANK;
                    w_holdNext  = '0;
                end else begin
                    w_holdNext = r_holdCnt + 1'b1;
                end
            end
            ST_BLANK: begin
                w_stateNext = ST_SHOW;
                w_holdNext  = '0;
                if (r_row != C_LAST_ROW) begin
                    w_rowNext = r_row + 1'b1;
                end else begin
                    // Frame boundary: take a waiting frame, else repeat the current one.
                    w_rowNext = '0;
                    if (r_backFull) begin
                        w_swap = 1'b1;
                    end else if (!r_frontValid) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_rowNext   = '0;
                w_holdNext  = '0;
            end
        endcase
    end

    assign w_frontNext = r_frontSel ^ w_swap;
    assign w_showNext  = (w_stateNext == ST_SHOW);

    always_ff @(posedge cnt) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_holdCnt    <= '0;
            r_frontValid <= 1'b0;
            r_frontSel   <= 1'b0;
            row_en       <= 1'b0;
            col_out      <= '0;
            frame_swap   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_row      <= w_rowNext;
            r_holdCnt  <= w_holdNext;
            r_frontSel <= w_frontNext;
            if (w_swap) begin
                r_frontValid <= 1'b1;
            end
            row_en     <= w_showNext;
            frame_swap <= w_swap;
            col_out    <= w_showNext ? r_mem[w_frontNext][w_rowNext] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_scan_driver
// Brief    : Directed scoreboard bench for row_scan_driver (HOLD=4, ROWS=41).
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_scan_driver;

    localparam int WIDTH  = 80;
    localparam int ROWS   = 41;
    localparam int HOLD   = 4;
    localparam int SEL_W  = 6;
    localparam int PERIOD = ROWS * (HOLD + 1);

    logic             cnt = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] row_in = '0;
    logic             row_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             row_ready;
    logic [WIDTH-1:0] col_out;
    logic [SEL_W-1:0] row_sel;
    logic             row_en;
    logic             frame_swap;

    always #5 cnt = ~cnt;

    row_scan_driver #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .HOLD  (HOLD),
        .SEL_W (SEL_W)
    ) dut (
        .cnt         (cnt),
        .rst         (rst),
        .row_in      (row_in),
        .row_valid   (row_valid),
        .frame_start (frame_start),
        .row_ready   (row_ready),
        .col_out     (col_out),
        .row_sel     (row_sel),
        .row_en      (row_en),
        .frame_swap  (frame_swap)
    );

    int               nChecks = 0;
    int               nErrors = 0;
    logic [WIDTH-1:0] sbQ [$];
    logic [WIDTH-1:0] expFront [ROWS];
    int               wrCount = 0;
    bit               backFull = 1'b0;
    bit               scanning = 1'b0;
    bit               lastSwap = 1'b0;
    int               scanPos = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nChecks++;
        assert (got === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: model decisions use pre-edge state, outputs checked #1 after.
    task automatic tick();
        bit               accept;
        bit               swapNow;
        bit               fs;
        bit               en;
        int               r;
        logic [WIDTH-1:0] data;
        accept  = !rst && row_valid && !backFull;
        swapNow = !rst && backFull && (!scanning || scanPos == PERIOD - 1);
        fs      = frame_start;
        data    = row_in;
        chk("row_ready", 96'(row_ready), 96'(!backFull));
        @(posedge cnt);
        #1;
        if (rst) begin
            sbQ.delete();
            wrCount  = 0;
            backFull = 1'b0;
            scanning = 1'b0;
            scanPos  = 0;
        end else begin
            if (accept) begin
                if (fs) begin
                    sbQ.delete();
                    wrCount = 0;
                end
                sbQ.push_back(data);
                wrCount++;
                if (wrCount == ROWS) begin
                    wrCount  = 0;
                    backFull = 1'b1;
                end
            end
            if (swapNow) begin
                backFull = 1'b0;
                if (sbQ.size() < ROWS) begin
                    chk("sb_underflow", 96'(sbQ.size()), 96'(ROWS));
                end else begin
                    for (int k = 0; k < ROWS; k++) expFront[k] = sbQ.pop_front();
                end
            end
            if (scanning) begin
                scanPos = (scanPos + 1) % PERIOD;
            end else if (swapNow) begin
                scanning = 1'b1;
                scanPos  = 0;
            end
        end
        lastSwap = swapNow;
        if (scanning) begin
            r  = scanPos / (HOLD + 1);
            en = (scanPos % (HOLD + 1)) < HOLD;
            chk("scan", 96'({row_en, frame_swap, row_sel, col_out}),
                96'({en, swapNow, SEL_W'(r), en ? expFront[r] : {WIDTH{1'b0}}}));
        end else begin
            chk("idle", 96'({row_en, frame_swap, row_sel, col_out}), 96'd0);
        end
    endtask

    task automatic sendRow(input logic [WIDTH-1:0] data, input bit fs);
        row_valid   = 1'b1;
        row_in      = data;
        frame_start = fs;
        tick();
        row_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge cnt);
        #1;
        chk("reset_state", 96'({row_en, frame_swap, row_ready, row_sel, col_out}),
            96'({1'b0, 1'b0, 1'b1, 6'd0, 80'd0}));
        rst = 1'b0;
        repeat (200) tick();

        // First frame: row k carries k in its low byte.
        for (int k = 0; k < ROWS; k++) sendRow(WIDTH'(k), k == 0);
        chk("ready_low_after_last", 96'(row_ready), 96'd0);
        tick();
        chk("first_swap", 96'({frame_swap, row_en, row_sel, col_out, row_ready}),
            96'({1'b1, 1'b1, 6'd0, 80'd0, 1'b1}));
        repeat (200) tick();
        chk("row40_data", 96'({row_en, row_sel, col_out}), 96'({1'b1, 6'd40, 80'h28}));
        repeat (5) tick();
        chk("repeat_row0", 96'({frame_swap, row_en, row_sel, col_out}),
            96'({1'b0, 1'b1, 6'd0, 80'd0}));

        // Frame B loaded during frame A's repeat; swap at frame end.
        for (int k = 0; k < ROWS; k++) sendRow({WIDTH{1'b1}}, k == 0);
        chk("ready_low_B", 96'(row_ready), 96'd0);
        for (int i = 0; i < PERIOD && scanPos != PERIOD - 1; i++) tick();
        chk("pre_swap_blank", 96'({row_ready, row_en, row_sel}), 96'({1'b0, 1'b0, 6'd40}));
        tick();
        chk("swap_B", 96'({frame_swap, row_sel, col_out, row_ready}),
            96'({1'b1, 6'd0, {WIDTH{1'b1}}, 1'b1}));

        // Resync: 10 stray rows, then a frame_start row plus 40 more.
        for (int k = 0; k < 10; k++) sendRow(WIDTH'(16'h0100 + k), 1'b0);
        sendRow(WIDTH'(16'h0200), 1'b1);
        for (int k = 1; k < ROWS; k++) sendRow(WIDTH'(16'h0200 + k), 1'b0);
        for (int i = 0; i < 2 * PERIOD && !lastSwap; i++) tick();
        chk("resync_swap", 96'({frame_swap, row_sel, col_out}), 96'({1'b1, 6'd0, 80'h200}));
        repeat (PERIOD - 1) tick();

        // Last row accepted during the final BLANK: swap deferred one frame.
        for (int i = 0; i < PERIOD && scanPos != PERIOD - ROWS; i++) tick();
        for (int k = 0; k < ROWS; k++) sendRow(WIDTH'(16'h0300 + k), k == 0);
        chk("late_no_swap", 96'({frame_swap, row_ready, row_sel, col_out}),
            96'({1'b0, 1'b0, 6'd0, 80'h200}));
        for (int i = 0; i < PERIOD && scanPos != PERIOD - 1; i++) tick();
        tick();
        chk("late_swap", 96'({frame_swap, row_sel, col_out}), 96'({1'b1, 6'd0, 80'h300}));

        // Reset during SHOW of row 17.
        for (int i = 0; i < PERIOD && scanPos != 17 * (HOLD + 1) + 1; i++) tick();
        chk("row17_show", 96'({row_en, row_sel}), 96'({1'b1, 6'd17}));
        rst = 1'b1;
        tick();
        chk("midscan_reset", 96'({row_en, row_sel, row_ready, frame_swap, col_out}),
            96'({1'b0, 6'd0, 1'b1, 1'b0, 80'd0}));
        rst = 1'b0;
        for (int k = 0; k < 20; k++) sendRow(WIDTH'(16'h0400 + k), k == 0);
        repeat (300) tick();
        for (int k = 0; k < ROWS; k++) sendRow(WIDTH'(16'h0500 + k), k == 0);
        tick();
        chk("post_reset_swap", 96'({frame_swap, row_en, col_out}), 96'({1'b1, 1'b1, 80'h500}));
        repeat (PERIOD) tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/row_scan_driver.md
Name: row_scan_driver

Overview:
- Downstream stage of the dinosaur/cactus image reader. Consumes the 80-bit image rows that the reader emits one per clock and collects them into a double-buffered frame store.
- Scans the completed frame row by row onto the LED dot-matrix column/row drivers.
- Decouples the image producer's row rate from the display refresh rate.

Parameters:
- WIDTH, 80, bits per image row (column count).
- ROWS, 41, rows per frame.
- HOLD, 1000, clock cycles each row is lit (>=1).
- SEL_W, 6, width of row_sel; must satisfy 2^SEL_W >= ROWS.

Ports:
- cnt  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- row_in  input  WIDTH  image row from the upstream reader.
- row_valid  input  1  row_in valid this cycle.
- frame_start  input  1  qualifies row_in as row 0 of a new frame; only meaningful with row_valid.
- row_ready  output  1  back buffer can accept a row.
- col_out  output  WIDTH  column drive for the lit row; registered.
- row_sel  output  SEL_W  index of the lit row; registered.
- row_en  output  1  row driver enable; registered.
- frame_swap  output  1  one-cycle pulse on the first cycle of a newly displayed frame.

Behaviour:
- Reset and interface:
  - Reset is synchronous, active-high. Clock port is cnt, reset port is rst.
  - On rst: col_out=0, row_sel=0, row_en=0, frame_swap=0, write index=0, back_full=0, front_valid=0, scan state=IDLE, hold counter=0.
  - RAM contents are not reset.
  - rst mid-operation discards both buffers; nothing is displayed until a new full frame arrives.
- Write side (back buffer):
  - row_ready = !back_full (combinational). Reset value is 1.
  - A row is accepted when row_valid && row_ready. It is written to back[wr_idx], then wr_idx increments.
  - If frame_start is set on an accepted row, that row is written to index 0 and wr_idx becomes 1. Any partial frame is discarded (resync).
  - Accepting the row at index ROWS-1 sets back_full on the next cycle and wraps wr_idx to 0.
  - While back_full=1, row_valid and frame_start are ignored.
- Scan states:
  - IDLE:
    - row_en=0, col_out=0.
    - When back_full=1, swap buffers, clear back_full, set front_valid, and enter SHOW with row 0.
  - SHOW:
    - row_en=1, row_sel=r, col_out=front[r], for exactly HOLD cycles.
    - Then enter BLANK.
  - BLANK (exactly 1 cycle, anti-ghosting):
    - row_en=0, col_out=0, row_sel holds r.
    - If r<ROWS-1: go to SHOW with r+1.
    - If r=ROWS-1 and back_full=1: swap buffers, clear back_full, go to SHOW with r=0.
    - If r=ROWS-1 and back_full=0: repeat the current front frame from r=0.
- Timing:
  - Row period = HOLD+1 cycles. Frame period = ROWS*(HOLD+1) cycles.
  - frame_swap=1 on the first SHOW cycle of row 0 after every swap, including the first swap out of IDLE. It is 0 otherwise.
  - Latency from acceptance of the last row to the first lit row, when starting from IDLE: 2 cycles. Cycle 1: back_full registered. Cycle 2: SHOW outputs registered.
- Boundary conditions:
  - If the last row is accepted in the same cycle as the BLANK of row ROWS-1, back_full is not yet visible. The swap waits one full frame.
  - row_ready reasserts the cycle after the swap. The producer can refill while the new front frame is displayed.
  - A producer that stops mid-frame leaves the frame partial and row_ready stays 1. The display keeps repeating the old front frame.
  - All index and counter arithmetic is unsigned. The hold counter is wide enough for HOLD-1, and wraps to 0 at HOLD-1.

Test Plan (HOLD=4, ROWS=41 unless noted):
- Reset then idle. Hold rst for 3 cycles, then release with no row_valid for 200 cycles. Required: row_en=0, col_out=0, frame_swap=0, row_ready=1 throughout.
- First frame. Stream 41 rows back-to-back; row k = k replicated in the low byte, row 0 with frame_start. Required:
  - row_ready falls after row 40.
  - Two cycles later frame_swap=1, row_en=1, row_sel=0, col_out=0x00.
  - Each row is held 4 cycles followed by 1 blank cycle.
  - row_sel=40 shows col_out=0x28.
- Repeat without a new frame. After the first frame, send no rows. Required: frame_swap stays 0; row 0 reappears 205 cycles after it was first lit, with identical data.
- Swap at frame end. While frame A is shown, load frame B (all rows 0xFF..FF) fully before A's row 40. Required:
  - row_ready=0 from B's completion until the swap.
  - The swap happens after row 40's blank.
  - The next cycle shows frame_swap=1, row_sel=0, col_out=all ones.
  - row_ready=1 on that cycle.
- Resync. Send 10 rows, then a row with frame_start=1, then 40 more rows. Required: the displayed frame consists of the frame_start row plus the 40 following rows; the first 10 rows never appear.
- Reset mid-scan. Assert rst during SHOW of row 17. Required: the next cycle shows row_en=0, row_sel=0, row_ready=1, IDLE state; no display until a new full 41-row frame arrives.
